// File: rtl/cart_sram_if.sv
// Bus bundle between the cartridge SRAM arbiter, its two requesters and the SRAM pins.
// The master view belongs to the arbiter; the slave view belongs to requesters and the SRAM.
interface cart_sram_if;
  logic        host_req;
  logic [12:0] host_addr;
  logic [7:0]  host_wdata;
  logic        host_we;
  logic        host_gnt;
  logic [7:0]  host_rdata;
  logic        host_rvalid;

  logic        cap_req;
  logic [11:0] cap_addr;
  logic [7:0]  cap_wdata;
  logic        cap_nCS;
  logic        cap_nWE;
  logic        cap_gnt;

  logic [12:0] sram_addr;
  logic [7:0]  sram_dout;
  logic        sram_dout_en;
  logic        sram_nCS;
  logic        sram_nWE;
  logic        sram_nOE;
  logic [7:0]  sram_din;

  modport master (
    input  host_req, host_addr, host_wdata, host_we,
    output host_gnt, host_rdata, host_rvalid,
    input  cap_req, cap_addr, cap_wdata, cap_nCS, cap_nWE,
    output cap_gnt,
    output sram_addr, sram_dout, sram_dout_en, sram_nCS, sram_nWE, sram_nOE,
    input  sram_din
  );

  modport slave (
    output host_req, host_addr, host_wdata, host_we,
    input  host_gnt, host_rdata, host_rvalid,
    output cap_req, cap_addr, cap_wdata, cap_nCS, cap_nWE,
    input  cap_gnt,
    input  sram_addr, sram_dout, sram_dout_en, sram_nCS, sram_nWE, sram_nOE,
    output sram_din
  );
endinterface

// File: rtl/cart_sram_arbiter.sv
// Shares the cartridge SRAM between host accesses and the capture writer, with a
// strobe-idle turnaround before every grant and a starvation escape for the capture side.
//
// state | meaning
// IDLE  | no owner, strobes inactive, picking the next target
// TURN  | turnaround, strobes inactive for TURN_CYCLES before granting target
// HOST  | host owns the SRAM bus
// CAP   | capture writer owns the SRAM bus
module cart_sram_arbiter #(
  parameter int TURN_CYCLES  = 2,
  parameter int STARVE_LIMIT = 64,
  parameter int RD_CYCLES    = 3
) (
  input logic         sys_clock,
  input logic         sys_resetn,
  cart_sram_if.master bus
);
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam int TURN_W   = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam int RD_W     = (RD_CYCLES > 1) ? $clog2(RD_CYCLES) : 1;
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
  localparam logic [TURN_W-1:0]   TURN_LOAD  = TURN_W'(TURN_CYCLES - 1);
  localparam logic [RD_W-1:0]     RD_LAST    = RD_W'(RD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, TURN, HOST, CAP} stateType;
  typedef enum logic {TGT_HOST, TGT_CAP} targetType;

  stateType            state, nextState;
  targetType           target, nextTarget;
  logic [TURN_W-1:0]   turnCnt, nextTurnCnt;
  logic [STARVE_W-1:0] starveCnt;
  logic [RD_W-1:0]     rdCnt;
  logic                rdDone;
  logic                targetReq;

  assign targetReq    = (target == TGT_CAP) ? bus.cap_req : bus.host_req;
  assign bus.host_gnt = (state == HOST);
  assign bus.cap_gnt  = (state == CAP);

  always_ff @(posedge sys_clock) begin
    if (!sys_resetn) begin
      state   <= IDLE;
      target  <= TGT_HOST;
      turnCnt <= '0;
    end else begin
      state   <= nextState;
      target  <= nextTarget;
      turnCnt <= nextTurnCnt;
    end
  end

  always_comb begin
    nextState   = state;
    nextTarget  = target;
    nextTurnCnt = turnCnt;
    case (state)
      IDLE: begin
        if (bus.cap_req && starveCnt == STARVE_MAX) begin
          nextState   = TURN;
          nextTarget  = TGT_CAP;
          nextTurnCnt = TURN_LOAD;
        end else if (bus.host_req) begin
          nextState   = TURN;
          nextTarget  = TGT_HOST;
          nextTurnCnt = TURN_LOAD;
        end else if (bus.cap_req) begin
          nextState   = TURN;
          nextTarget  = TGT_CAP;
          nextTurnCnt = TURN_LOAD;
        end
      end
      TURN: begin
        if (!targetReq) begin
          nextState = IDLE;
        end else if (turnCnt == '0) begin
          nextState = (target == TGT_CAP) ? CAP : HOST;
        end else begin
          nextTurnCnt = turnCnt - 1'b1;
        end
      end
      HOST: if (!bus.host_req) nextState = IDLE;
      CAP:  if (!bus.cap_req) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Capture wait time; saturates so a long host hold forces the next win to capture.
  always_ff @(posedge sys_clock) begin
    if (!sys_resetn) begin
      starveCnt <= '0;
    end else if (!bus.cap_req || (nextState == CAP && state != CAP)) begin
      starveCnt <= '0;
    end else if (state != CAP && starveCnt != STARVE_MAX) begin
      starveCnt <= starveCnt + 1'b1;
    end
  end

  always_ff @(posedge sys_clock) begin
    if (!sys_resetn) begin
      bus.sram_addr    <= '0;
      bus.sram_dout    <= '0;
      bus.sram_dout_en <= 1'b0;
      bus.sram_nCS     <= 1'b1;
      bus.sram_nWE     <= 1'b1;
      bus.sram_nOE     <= 1'b1;
    end else begin
      case (state)
        CAP: begin
          bus.sram_addr    <= {1'b0, bus.cap_addr};
          bus.sram_dout    <= bus.cap_wdata;
          bus.sram_nCS     <= bus.cap_nCS;
          bus.sram_nWE     <= bus.cap_nWE;
          bus.sram_nOE     <= 1'b1;
          bus.sram_dout_en <= !bus.cap_nCS;
        end
        HOST: begin
          bus.sram_addr <= bus.host_addr;
          bus.sram_nCS  <= 1'b0;
          if (bus.host_we) begin
            bus.sram_dout    <= bus.host_wdata;
            bus.sram_nWE     <= 1'b0;
            bus.sram_nOE     <= 1'b1;
            bus.sram_dout_en <= 1'b1;
          end else begin
            bus.sram_nWE     <= 1'b1;
            bus.sram_nOE     <= 1'b0;
            bus.sram_dout_en <= 1'b0;
          end
        end
        default: begin
          bus.sram_nCS     <= 1'b1;
          bus.sram_nWE     <= 1'b1;
          bus.sram_nOE     <= 1'b1;
          bus.sram_dout_en <= 1'b0;
        end
      endcase
    end
  end

  // One read sample per grant, after nOE has been low for RD_CYCLES full cycles.
  always_ff @(posedge sys_clock) begin
    if (!sys_resetn) begin
      rdCnt           <= '0;
      rdDone          <= 1'b0;
      bus.host_rdata  <= '0;
      bus.host_rvalid <= 1'b0;
    end else begin
      bus.host_rvalid <= 1'b0;
      if (state != HOST) begin
        rdCnt  <= '0;
        rdDone <= 1'b0;
      end else if (!bus.host_we && !bus.sram_nOE && !rdDone) begin
        if (rdCnt == RD_LAST) begin
          bus.host_rdata  <= bus.sram_din;
          bus.host_rvalid <= 1'b1;
          rdDone          <= 1'b1;
        end else begin
          rdCnt <= rdCnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_cart_sram_arbiter.sv
// Bench for cart_sram_arbiter: directed arbitration scenarios plus random request traffic,
// every cycle compared against a phase/owner reference model of the arbitration rules.
module tb_cart_sram_arbiter;
  localparam int TURN_CYCLES  = 2;
  localparam int STARVE_LIMIT = 64;
  localparam int RD_CYCLES    = 3;
  localparam int PH_IDLE = 0, PH_WAIT = 1, PH_OWNED = 2;
  localparam int OWN_NONE = 0, OWN_HOST = 1, OWN_CAP = 2;

  logic sys_clock = 1'b0;
  logic sys_resetn = 1'b0;
  int   checks = 0;
  int   failures = 0;

  cart_sram_if bus();

  cart_sram_arbiter #(
    .TURN_CYCLES(TURN_CYCLES),
    .STARVE_LIMIT(STARVE_LIMIT),
    .RD_CYCLES(RD_CYCLES)
  ) dut (
    .sys_clock(sys_clock),
    .sys_resetn(sys_resetn),
    .bus(bus)
  );

  always #5 sys_clock = ~sys_clock;

  // Reference model: who owns the bus, how long the turnaround has run, how long capture waited.
  int          mPhase = PH_IDLE;
  int          mOwner = OWN_NONE;
  int          mTurn = 0;
  int          mWait = 0;
  int          mLow = 0;
  bit          mTaken = 1'b0;
  logic [12:0] eAddr = '0;
  logic [7:0]  eDout = '0;
  logic        eEn = 1'b0, eCs = 1'b1, eWe = 1'b1, eOe = 1'b1;
  logic [7:0]  eRdata = '0;
  logic        eRvalid = 1'b0;

  always @(posedge sys_clock) begin : modelStep
    bit wasCap, nowCap, ownerReq;
    if (!sys_resetn) begin
      mPhase = PH_IDLE; mOwner = OWN_NONE; mTurn = 0; mWait = 0; mLow = 0; mTaken = 1'b0;
      eAddr = '0; eDout = '0; eEn = 1'b0; eCs = 1'b1; eWe = 1'b1; eOe = 1'b1;
      eRdata = '0; eRvalid = 1'b0;
    end else begin
      eRvalid = 1'b0;
      if (mPhase == PH_OWNED && mOwner == OWN_HOST && !bus.host_we && !eOe) begin
        mLow++;
        if (mLow == RD_CYCLES && !mTaken) begin
          eRdata = bus.sram_din; eRvalid = 1'b1; mTaken = 1'b1;
        end
      end
      if (mPhase == PH_OWNED && mOwner == OWN_CAP) begin
        eAddr = {1'b0, bus.cap_addr}; eDout = bus.cap_wdata; eCs = bus.cap_nCS;
        eWe = bus.cap_nWE; eOe = 1'b1; eEn = !bus.cap_nCS;
      end else if (mPhase == PH_OWNED && mOwner == OWN_HOST) begin
        eAddr = bus.host_addr; eCs = 1'b0;
        if (bus.host_we) begin
          eWe = 1'b0; eOe = 1'b1; eEn = 1'b1; eDout = bus.host_wdata;
        end else begin
          eWe = 1'b1; eOe = 1'b0; eEn = 1'b0;
        end
      end else begin
        eCs = 1'b1; eWe = 1'b1; eOe = 1'b1; eEn = 1'b0;
      end
      wasCap = (mPhase == PH_OWNED && mOwner == OWN_CAP);
      ownerReq = (mOwner == OWN_CAP) ? bus.cap_req : bus.host_req;
      case (mPhase)
        PH_IDLE: begin
          if (bus.cap_req && mWait == STARVE_LIMIT) begin
            mPhase = PH_WAIT; mOwner = OWN_CAP; mTurn = 0;
          end else if (bus.host_req) begin
            mPhase = PH_WAIT; mOwner = OWN_HOST; mTurn = 0;
          end else if (bus.cap_req) begin
            mPhase = PH_WAIT; mOwner = OWN_CAP; mTurn = 0;
          end
        end
        PH_WAIT: begin
          if (!ownerReq) mPhase = PH_IDLE;
          else begin
            mTurn++;
            if (mTurn == TURN_CYCLES) begin
              mPhase = PH_OWNED; mLow = 0; mTaken = 1'b0;
            end
          end
        end
        default: if (!ownerReq) mPhase = PH_IDLE;
      endcase
      nowCap = (mPhase == PH_OWNED && mOwner == OWN_CAP);
      if (!bus.cap_req || (nowCap && !wasCap)) mWait = 0;
      else if (!wasCap && mWait < STARVE_LIMIT) mWait++;
    end
  end

  task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic checkCycle();
    checkVal("host_gnt", 32'(bus.host_gnt), 32'(mPhase == PH_OWNED && mOwner == OWN_HOST));
    checkVal("cap_gnt", 32'(bus.cap_gnt), 32'(mPhase == PH_OWNED && mOwner == OWN_CAP));
    checkVal("gnt_excl", 32'(bus.host_gnt & bus.cap_gnt), 32'(0));
    checkVal("sram_pins",
             32'({bus.sram_addr, bus.sram_dout, bus.sram_dout_en, bus.sram_nCS, bus.sram_nWE, bus.sram_nOE}),
             32'({eAddr, eDout, eEn, eCs, eWe, eOe}));
    checkVal("host_rvalid", 32'(bus.host_rvalid), 32'(eRvalid));
    checkVal("host_rdata", 32'(bus.host_rdata), 32'(eRdata));
  endtask

  task automatic tick();
    @(negedge sys_clock);
    checkCycle();
  endtask

  task automatic capIdle();
    bus.cap_req = 1'b0; bus.cap_nCS = 1'b1; bus.cap_nWE = 1'b1;
  endtask

  initial begin
    int rvCount;
    bus.host_req = 1'b0; bus.host_addr = '0; bus.host_wdata = '0; bus.host_we = 1'b0;
    bus.cap_addr = '0; bus.cap_wdata = '0; bus.sram_din = '0;
    capIdle();
    repeat (3) tick();
    checkVal("rst_pins", 32'({bus.sram_addr, bus.sram_dout, bus.sram_dout_en, bus.sram_nCS, bus.sram_nWE, bus.sram_nOE}),
             32'({13'h0, 8'h0, 1'b0, 3'b111}));
    checkVal("rst_gnts", 32'({bus.host_gnt, bus.cap_gnt, bus.host_rvalid}), 32'(0));
    sys_resetn = 1'b1;
    repeat (2) tick();

    // capture alone: grant after the turnaround, pins one cycle after the grant
    bus.cap_req = 1'b1; bus.cap_addr = 12'h123; bus.cap_wdata = 8'hA5; bus.cap_nCS = 1'b0; bus.cap_nWE = 1'b0;
    tick(); checkVal("A_turn1", 32'(bus.cap_gnt), 32'(0));
    tick(); checkVal("A_turn2", 32'(bus.cap_gnt), 32'(0));
    tick(); checkVal("A_cap_gnt", 32'(bus.cap_gnt), 32'(1));
    checkVal("A_pins_late", 32'(bus.sram_nCS), 32'(1));
    tick(); checkVal("A_addr", 32'(bus.sram_addr), 32'h0123);
    checkVal("A_nwe", 32'({bus.sram_nWE, bus.sram_dout_en}), 32'({1'b0, 1'b1}));
    capIdle();
    tick(); checkVal("A_release", 32'(bus.cap_gnt), 32'(0));
    repeat (2) tick();

    // simultaneous requests: host first, capture after host drops
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 13'h0456; bus.host_wdata = 8'h3C;
    bus.cap_req = 1'b1; bus.cap_addr = 12'h077; bus.cap_nCS = 1'b0; bus.cap_nWE = 1'b0;
    repeat (3) tick();
    checkVal("B_host_first", 32'({bus.host_gnt, bus.cap_gnt}), 32'({1'b1, 1'b0}));
    repeat (4) tick();
    bus.host_req = 1'b0;
    tick(); checkVal("B_drop", 32'({bus.host_gnt, bus.cap_gnt}), 32'(0));
    tick(); tick(); checkVal("B_turn", 32'(bus.cap_gnt), 32'(0));
    tick(); checkVal("B_cap_gnt", 32'(bus.cap_gnt), 32'(1));
    capIdle();
    repeat (3) tick();

    // host read: one rvalid pulse after three nOE-low cycles
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 13'h1ABC; bus.sram_din = 8'h5A;
    repeat (3) tick();
    checkVal("C_host_gnt", 32'(bus.host_gnt), 32'(1));
    tick(); checkVal("C_noe", 32'({bus.sram_nOE, bus.sram_addr}), 32'({1'b0, 13'h1ABC}));
    tick(); checkVal("C_rv_early1", 32'(bus.host_rvalid), 32'(0));
    tick(); checkVal("C_rv_early2", 32'(bus.host_rvalid), 32'(0));
    tick(); checkVal("C_rvalid", 32'(bus.host_rvalid), 32'(1));
    checkVal("C_rdata", 32'(bus.host_rdata), 32'h5A);
    rvCount = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      rvCount += int'(bus.host_rvalid);
    end
    checkVal("C_single_pulse", 32'(rvCount), 32'(0));
    bus.host_req = 1'b0;
    repeat (3) tick();

    // starvation: capture waits through a long host grant, then beats a host re-request
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 13'h0AAA; bus.host_wdata = 8'h11;
    repeat (3) tick();
    bus.cap_req = 1'b1; bus.cap_nCS = 1'b0; bus.cap_nWE = 1'b0; bus.cap_addr = 12'h321;
    repeat (70) tick();
    checkVal("D_host_holds", 32'({bus.host_gnt, bus.cap_gnt}), 32'({1'b1, 1'b0}));
    bus.host_req = 1'b0;
    tick();
    bus.host_req = 1'b1;
    repeat (3) tick();
    checkVal("D_cap_wins", 32'({bus.host_gnt, bus.cap_gnt}), 32'({1'b0, 1'b1}));
    repeat (5) tick();
    checkVal("D_no_preempt", 32'({bus.host_gnt, bus.cap_gnt}), 32'({1'b0, 1'b1}));
    capIdle();
    repeat (4) tick();
    checkVal("D_host_after", 32'(bus.host_gnt), 32'(1));
    bus.host_req = 1'b0;
    repeat (3) tick();

    // host request withdrawn during turnaround
    bus.host_req = 1'b1; bus.host_we = 1'b0;
    tick();
    bus.host_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checkVal("E_no_gnt", 32'({bus.host_gnt, bus.cap_gnt}), 32'(0));
      checkVal("E_strobes", 32'({bus.sram_nCS, bus.sram_nWE, bus.sram_nOE}), 32'(3'b111));
    end

    // reset in the middle of a capture write
    bus.cap_req = 1'b1; bus.cap_nCS = 1'b0; bus.cap_nWE = 1'b0; bus.cap_addr = 12'h0F0;
    repeat (4) tick();
    checkVal("F_nwe_low", 32'(bus.sram_nWE), 32'(0));
    sys_resetn = 1'b0;
    tick();
    checkVal("F_rst_strobes", 32'({bus.sram_nWE, bus.sram_nCS}), 32'({1'b1, 1'b1}));
    checkVal("F_rst_gnt", 32'({bus.cap_gnt, bus.host_gnt}), 32'(0));
    sys_resetn = 1'b1;
    capIdle();
    repeat (3) tick();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if (bus.host_req) begin
        if ($urandom_range(39) == 0) bus.host_req = 1'b0;
      end else if ($urandom_range(3) == 0) begin
        bus.host_req = 1'b1;
        bus.host_we = 1'($urandom_range(1));
        bus.host_addr = 13'($urandom);
        bus.host_wdata = 8'($urandom);
      end
      if (bus.cap_req) begin
        if ($urandom_range(24) == 0) bus.cap_req = 1'b0;
      end else if ($urandom_range(7) == 0) begin
        bus.cap_req = 1'b1;
      end
      bus.cap_addr = 12'($urandom);
      bus.cap_wdata = 8'($urandom);
      bus.cap_nCS = 1'($urandom_range(1));
      bus.cap_nWE = 1'($urandom_range(1));
      bus.sram_din = 8'($urandom);
      sys_resetn = ($urandom_range(499) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end
endmodule
